wall_column_builder: RTL and testbench

- Downstream of the ray calculator. On each ray_done pulse it captures the perpendicular wall distance (Q4.8) and hit side for the current ray_index.
- Computes the on-screen wall slice height as SCREEN_H / distance with a bit-serial divider, then derives draw_start/draw_end.
- Writes {draw_start, draw_end, side} into a ping-pong column buffer (2 banks x SCREEN_W entries). The VGA renderer reads the bank not being written.

---
 rtl/wall_column_builder_pkg.sv | 53 +++++
 rtl/wall_column_builder_if.sv | 29 ++
 rtl/wall_column_builder_serial_divider.sv | 57 +++++
 rtl/wall_column_builder.sv | 128 ++++++++++++
 tb/tb_wall_column_builder.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/wall_column_builder_pkg.sv
// Shared constants, FSM encoding and column-entry layout for the wall column builder.
// The helper turns a raw divider quotient into a clamped, centred wall slice.
package wall_column_builder_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int DIST_W    = 12;
    localparam int ROW_W     = 9;
    localparam int FRAC_BITS = 8;
    localparam int COL_W     = 10;
    localparam int NUM_W     = 17;
    localparam int DIV_STEPS = NUM_W;

    localparam logic [NUM_W-1:0] DIV_NUMERATOR = NUM_W'(SCREEN_H << FRAC_BITS);
    localparam logic [COL_W-1:0] COL_LIMIT     = COL_W'(SCREEN_W);
    localparam logic [COL_W-1:0] LAST_COL      = COL_W'(SCREEN_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX       = ROW_W'(SCREEN_H);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_CALC,
        ST_WRITE
    } state_t;

    typedef struct packed {
        logic [ROW_W-1:0] draw_start;
        logic [ROW_W-1:0] draw_end;
        logic             side;
    } col_entry_t;

    // Height is clamped to [1, SCREEN_H]; the all-ones divide-by-zero result clamps too.
    function automatic col_entry_t slice_from_quotient(input logic [NUM_W-1:0] q,
                                                       input logic side);
        col_entry_t       e;
        logic [ROW_W-1:0] h;
        logic [ROW_W-1:0] s;
        if (q > NUM_W'(SCREEN_H)) begin
            h = ROW_MAX;
        end else begin
            h = q[ROW_W-1:0];
        end
        if (h == '0) begin
            h = ROW_W'(1);
        end
        s            = (ROW_MAX - h) >> 1;
        e.draw_start = s;
        e.draw_end   = s + h - ROW_W'(1);
        e.side       = side;
        return e;
    endfunction

endpackage

// File: rtl/wall_column_builder_if.sv
// Ray-input and column-read signals of the wall column builder.
// The master side is the ray tracer plus renderer; the slave side is the builder.
interface wall_column_builder_if;
    import wall_column_builder_pkg::*;

    logic              ray_done;
    logic [DIST_W-1:0] distance_x;
    logic [DIST_W-1:0] distance_y;
    logic              prev_side;
    logic [COL_W-1:0]  ray_index;
    logic              ready;
    logic [COL_W-1:0]  rd_col;
    logic [ROW_W-1:0]  rd_start;
    logic [ROW_W-1:0]  rd_end;
    logic              rd_side;
    logic              frame_swap;
    logic              overrun;

    modport slave (
        input  ray_done, distance_x, distance_y, prev_side, ray_index, rd_col,
        output ready, rd_start, rd_end, rd_side, frame_swap, overrun
    );

    modport master (
        output ray_done, distance_x, distance_y, prev_side, ray_index, rd_col,
        input  ready, rd_start, rd_end, rd_side, frame_swap, overrun
    );

endinterface

// File: rtl/wall_column_builder_serial_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses 17 cycles after start.
// A zero divisor naturally yields an all-ones quotient.
module wall_column_builder_serial_divider
    import wall_column_builder_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NUM_W-1:0]  numerator,
    input  logic [DIST_W-1:0] divisor,
    output logic              done,
    output logic [NUM_W-1:0]  quotient
);

    logic [DIST_W-1:0] rem;
    logic [DIST_W-1:0] dvs;
    logic [NUM_W-1:0]  quo;
    logic [4:0]        cnt;
    logic              busy;

    logic [DIST_W:0]   rem_shift;
    logic              fits;
    logic [DIST_W-1:0] rem_sub;

    // The difference is always below the divisor, so 12-bit modular subtraction is exact.
    assign rem_shift = {rem, quo[NUM_W-1]};
    assign fits      = rem_shift >= {1'b0, dvs};
    assign rem_sub   = rem_shift[DIST_W-1:0] - dvs;
    assign quotient  = quo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem  <= '0;
            dvs  <= '0;
            quo  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (start) begin
            rem  <= '0;
            dvs  <= divisor;
            quo  <= numerator;
            cnt  <= 5'(DIV_STEPS);
            busy <= 1'b1;
            done <= 1'b0;
        end else if (busy) begin
            rem  <= fits ? rem_sub : rem_shift[DIST_W-1:0];
            quo  <= {quo[NUM_W-2:0], fits};
            cnt  <= cnt - 5'd1;
            busy <= (cnt != 5'd1);
            done <= (cnt == 5'd1);
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/wall_column_builder.sv
// Turns each finished ray into a wall slice {draw_start, draw_end, side} in a ping-pong column buffer.
// The renderer reads the display bank while the tracer fills the other; the last column swaps them.
module wall_column_builder
    import wall_column_builder_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    wall_column_builder_if.slave  bus
);

    state_t            state;
    state_t            state_next;
    logic [DIST_W-1:0] dist_in;
    logic [DIST_W-1:0] dist_q;
    logic              side_q;
    logic [COL_W-1:0]  idx_q;
    col_entry_t        entry_q;
    logic              wr_bank;
    logic              disp_bank;
    logic              accept;
    logic              div_start;
    logic              div_done;
    logic              wr_en;
    logic              swap;
    logic              overrun_q;
    logic              frame_swap_q;
    logic [NUM_W-1:0]  div_quotient;
    logic [NUM_W-1:0]  quotient_eff;
    col_entry_t        rd_entry;

    col_entry_t        mem [2][SCREEN_W];

    assign dist_in      = bus.prev_side ? bus.distance_y : bus.distance_x;
    assign accept       = (state == ST_IDLE) && bus.ray_done && (bus.ray_index < COL_LIMIT);
    assign div_start    = accept && (dist_in != '0);
    assign quotient_eff = (dist_q == '0) ? NUM_W'(SCREEN_H) : div_quotient;

    assign bus.ready      = (state == ST_IDLE);
    assign bus.overrun    = overrun_q;
    assign bus.frame_swap = frame_swap_q;
    assign bus.rd_start   = rd_entry.draw_start;
    assign bus.rd_end     = rd_entry.draw_end;
    assign bus.rd_side    = rd_entry.side;

    wall_column_builder_serial_divider u_divider (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .numerator (DIV_NUMERATOR),
        .divisor   (dist_in),
        .done      (div_done),
        .quotient  (div_quotient)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        swap       = 1'b0;
        case (state)
            ST_IDLE:  if (accept) state_next = ST_DIV;
            // A zero distance never starts the divider and leaves after one cycle.
            ST_DIV:   if ((dist_q == '0) || div_done) state_next = ST_CALC;
            ST_CALC:  state_next = ST_WRITE;
            ST_WRITE: begin
                wr_en      = 1'b1;
                swap       = (idx_q == LAST_COL);
                state_next = ST_IDLE;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dist_q       <= '0;
            side_q       <= 1'b0;
            idx_q        <= '0;
            entry_q      <= '0;
            overrun_q    <= 1'b0;
            wr_bank      <= 1'b0;
            disp_bank    <= 1'b1;
            frame_swap_q <= 1'b0;
        end else begin
            if (accept) begin
                dist_q <= dist_in;
                side_q <= bus.prev_side;
                idx_q  <= bus.ray_index;
            end
            if (bus.ray_done && ((state != ST_IDLE) || (bus.ray_index >= COL_LIMIT))) begin
                overrun_q <= 1'b1;
            end
            if (state == ST_CALC) begin
                entry_q <= slice_from_quotient(quotient_eff, side_q);
            end
            if (swap) begin
                wr_bank   <= ~wr_bank;
                disp_bank <= ~disp_bank;
            end
            frame_swap_q <= swap;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][idx_q] <= entry_q;
        end
    end

    // Reads sample the bank select before any same-cycle swap takes effect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_entry <= '0;
        end else if (bus.rd_col < COL_LIMIT) begin
            rd_entry <= mem[disp_bank][bus.rd_col];
        end else begin
            rd_entry <= '0;
        end
    end

endmodule

// File: tb/tb_wall_column_builder.sv
// Directed bench for wall_column_builder: slice math, latency, overrun, bank swap and reset abort.
module tb_wall_column_builder;
    import wall_column_builder_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    wall_column_builder_if bus();

    wall_column_builder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ray(input logic side, input logic [11:0] dx, input logic [11:0] dy,
                            input logic [9:0] idx);
        bus.prev_side  = side;
        bus.distance_x = dx;
        bus.distance_y = dy;
        bus.ray_index  = idx;
        bus.ray_done   = 1'b1;
        step();
        bus.ray_done   = 1'b0;
    endtask

    task automatic wait_ready(output int n, output int swaps);
        n     = 0;
        swaps = 0;
        while (!bus.ready && n < 100) begin
            step();
            n++;
            if (bus.frame_swap) swaps++;
        end
    endtask

    task automatic ray_check(input string tag, input logic side, input logic [11:0] dx,
                             input logic [11:0] dy, input logic [9:0] idx,
                             input int exp_low, input int exp_swaps);
        int n;
        int s;
        send_ray(side, dx, dy, idx);
        wait_ready(n, s);
        check({tag, "_ready_low"}, n, exp_low);
        check({tag, "_swaps"}, s, exp_swaps);
    endtask

    task automatic read_check(input string tag, input logic [9:0] col, input int es,
                              input int ee, input logic eside);
        bus.rd_col = col;
        step();
        check({tag, "_start"}, bus.rd_start, es);
        check({tag, "_end"}, bus.rd_end, ee);
        check({tag, "_side"}, bus.rd_side, eside);
    endtask

    initial begin
        int n;
        int s;
        int lat_bad;
        int swaps_early;
        int swaps_last;
        logic [11:0] d;

        bus.ray_done   = 1'b0;
        bus.distance_x = '0;
        bus.distance_y = '0;
        bus.prev_side  = 1'b0;
        bus.ray_index  = '0;
        bus.rd_col     = '0;
        reset          = 1'b1;
        #1;
        check("rst_ready", bus.ready, 1);
        check("rst_swap", bus.frame_swap, 0);
        check("rst_overrun", bus.overrun, 0);
        step();
        step();
        check("rst_rd_start", bus.rd_start, 0);
        check("rst_rd_end", bus.rd_end, 0);
        check("rst_rd_side", bus.rd_side, 0);
        reset = 1'b0;
        step();

        // Bank 0 fill: h=240, 480, 480 (zero), 480 (clamped 960), 30.
        ray_check("a_x2p0", 1'b0, 12'h200, 12'hABC, 10'd5, 20, 0);
        ray_check("b_y1p0", 1'b1, 12'h800, 12'h100, 10'd6, 20, 0);
        ray_check("c_zero", 1'b0, 12'h000, 12'h000, 10'd7, 3, 0);
        ray_check("d_half", 1'b1, 12'h000, 12'h080, 10'd8, 20, 0);
        ray_check("e_max", 1'b0, 12'hFFF, 12'h000, 10'd9, 20, 0);
        check("no_overrun_yet", bus.overrun, 0);

        // Second ray_done three cycles into an in-flight ray.
        send_ray(1'b0, 12'h300, 12'h000, 10'd10);
        n = 0;
        step(); n++;
        step(); n++;
        bus.prev_side  = 1'b1;
        bus.distance_y = 12'h100;
        bus.ray_index  = 10'd11;
        bus.ray_done   = 1'b1;
        step(); n++;
        bus.ray_done   = 1'b0;
        check("ovr_flag", bus.overrun, 1);
        while (!bus.ready && n < 100) begin
            step();
            n++;
        end
        check("ovr_ready_low", n, 20);

        ray_check("g_last", 1'b1, 12'h000, 12'h400, 10'd639, 20, 1);
        step();
        check("swap_one_cycle", bus.frame_swap, 0);

        read_check("rd5", 10'd5, 120, 359, 1'b0);
        read_check("rd6", 10'd6, 0, 479, 1'b1);
        read_check("rd7", 10'd7, 0, 479, 1'b0);
        read_check("rd8", 10'd8, 0, 479, 1'b1);
        read_check("rd9", 10'd9, 225, 254, 1'b0);
        read_check("rd10", 10'd10, 160, 319, 1'b0);
        read_check("rd639", 10'd639, 180, 299, 1'b1);
        read_check("rd640", 10'd640, 0, 0, 1'b0);

        // Reset in the middle of a divide aimed at column 5.
        send_ray(1'b1, 12'h800, 12'h100, 10'd5);
        repeat (5) step();
        reset = 1'b1;
        #1;
        check("midrst_ready", bus.ready, 1);
        check("midrst_overrun", bus.overrun, 0);
        step();
        reset = 1'b0;
        step();

        send_ray(1'b0, 12'h100, 12'h000, 10'd700);
        check("idx700_overrun", bus.overrun, 1);
        check("idx700_ready", bus.ready, 1);

        // Swap bank 0 back to display: column 5 must not hold the aborted ray.
        ray_check("h_last", 1'b1, 12'h000, 12'h400, 10'd639, 20, 1);
        read_check("stale5", 10'd5, 120, 359, 1'b0);
        read_check("stale6", 10'd6, 0, 479, 1'b1);

        // Full frame into bank 1: distance cycles 0x200/0x400/0x300, side alternates.
        lat_bad     = 0;
        swaps_early = 0;
        swaps_last  = 0;
        for (int i = 0; i < SCREEN_W; i++) begin
            case (i % 3)
                0:       d = 12'h200;
                1:       d = 12'h400;
                default: d = 12'h300;
            endcase
            send_ray(i[0], d, d, 10'(i));
            wait_ready(n, s);
            if (n != 20) lat_bad++;
            if (i == SCREEN_W - 1) swaps_last = s;
            else swaps_early += s;
        end
        check("frame_latency_bad", lat_bad, 0);
        check("frame_swaps_early", swaps_early, 0);
        check("frame_swaps_last", swaps_last, 1);

        read_check("f0", 10'd0, 120, 359, 1'b0);
        read_check("f1", 10'd1, 180, 299, 1'b1);
        read_check("f2", 10'd2, 160, 319, 1'b0);
        read_check("f5", 10'd5, 160, 319, 1'b1);
        read_check("f320", 10'd320, 160, 319, 1'b0);
        read_check("f639", 10'd639, 120, 359, 1'b1);
        read_check("f1000", 10'd1000, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
